// File: rtl/tta_lsu_mem_bridge.sv
// tta_lsu_mem_bridge
// Bridges the TTA load/store FU's fixed-latency, active-low SRAM-style memory
// port onto a request/grant + read-valid bus with variable latency. When the
// bus misses the FU's one-cycle timing, the bridge raises glock_req to stall
// the core. Read data is buffered so it survives locks raised by other units.
//
// Optional feature macro: MEM_BRIDGE_TIMEOUT_EN
//   When defined, the TIMEOUT_CYC parameter, the sticky bus_err output and a
//   wait-cycle counter are added. A grant or read response that takes
//   TIMEOUT_CYC cycles aborts the transaction. If the read response times
//   out, 32'hDEADBEEF is returned to the FU for that one cycle.
//   When the macro is undefined, the bridge waits indefinitely.
module tta_lsu_mem_bridge #(
`ifdef MEM_BRIDGE_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYC = 255,
`endif
  parameter int unsigned ADDR_W = 22
) (
  input  logic              clk,
  input  logic              reset,
  // FU side (active-low controls)
  input  logic              lsu_mem_en_x,
  input  logic              lsu_wr_en_x,
  input  logic [31:0]       lsu_wr_mask_x,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic [31:0]       lsu_rdata,
  // Global lock
  input  logic              glock_other,
  output logic              glock_req,
`ifdef MEM_BRIDGE_TIMEOUT_EN
  output logic              bus_err,
`endif
  // Bus side
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_be,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_GNT = 2'd1,
    S_WAIT_RD  = 2'd2,
    S_HOLD     = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Request latch. It holds the last accepted FU request and feeds the bus
  // while the bridge waits for a grant.
  logic              req_we_q, req_we_d;
  logic [3:0]        req_be_q, req_be_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       req_wdata_q, req_wdata_d;

  // Last read data returned by the bus. The FU sees this value whenever no
  // fresh response is on the bus.
  logic [31:0]       rdata_buf_q, rdata_buf_d;

  // Request decoded from the FU's active-low signals
  logic              fu_we;
  logic [3:0]        fu_be;
  logic              accept_slot;
  logic              acc;
  state_t            acc_next;
  logic              timeout_hit;

  // The FU mask is bit-granular, but the bus only has byte enables. Only
  // bit 8*i of each byte is used, and the remaining bits are deliberately
  // ignored.
  logic              unused_mask_bits;

  assign unused_mask_bits = ^{lsu_wr_mask_x[31:25], lsu_wr_mask_x[23:17],
                              lsu_wr_mask_x[15:9],  lsu_wr_mask_x[7:1]};

  assign fu_we = ~lsu_wr_en_x;
  assign fu_be = fu_we ? ~{lsu_wr_mask_x[24], lsu_wr_mask_x[16],
                           lsu_wr_mask_x[8],  lsu_wr_mask_x[0]}
                       : 4'hF;

  // Decide in which states a new FU request can be taken this cycle
  always_comb begin
    accept_slot = 1'b0;
    unique case (state_q)
      S_IDLE:     accept_slot = 1'b1;
      S_HOLD:     accept_slot = ~glock_other;
      S_WAIT_RD:  accept_slot = bus_rvalid & ~glock_other;
      default:    accept_slot = 1'b0;
    endcase
  end

  // While reset is asserted, no request is presented to the bus, even if the
  // FU drives its enable.
  assign acc = reset & ~lsu_mem_en_x & accept_slot;

  // State that follows an accepted request, given the same-cycle grant
  assign acc_next = !bus_gnt ? S_WAIT_GNT : (fu_we ? S_IDLE : S_WAIT_RD);

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_err_q, bus_err_d;

  // An abort happens only when the awaited event is still missing in the
  // cycle the count reaches its limit. A late grant or rvalid wins.
  assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYC)) &&
                       (((state_q == S_WAIT_GNT) && !bus_gnt) ||
                        ((state_q == S_WAIT_RD)  && !bus_rvalid));

  // Count cycles spent waiting. The count restarts for every new request and
  // when a grant moves a read on to its data wait.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = bus_err_q | timeout_hit;
    if (acc || ((state_q == S_WAIT_GNT) && bus_gnt)) begin
      wait_cnt_d = '0;
    end else if ((state_q == S_WAIT_GNT) || (state_q == S_WAIT_RD)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Timeout counter and sticky error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state, request latch and bus/FU output decode
  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_be_d    = req_be_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rdata_buf_d = rdata_buf_q;

    bus_req     = 1'b0;
    bus_we      = req_we_q;
    bus_be      = req_be_q;
    bus_addr    = req_addr_q;
    bus_wdata   = req_wdata_q;
    glock_req   = 1'b0;
    lsu_rdata   = rdata_buf_q;

    // A freshly accepted request goes straight to the bus in the same cycle.
    // This is what allows zero-stall operation.
    if (acc) begin
      req_we_d    = fu_we;
      req_be_d    = fu_be;
      req_addr_d  = lsu_addr;
      req_wdata_d = lsu_wdata;
      bus_req     = 1'b1;
      bus_we      = fu_we;
      bus_be      = fu_be;
      bus_addr    = lsu_addr;
      bus_wdata   = lsu_wdata;
    end

    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          state_d = acc_next;
        end
      end

      S_WAIT_GNT: begin
        // The FU expected the access to complete already, so freeze the core
        glock_req = 1'b1;
        bus_req   = 1'b1;
        if (bus_gnt) begin
          state_d = req_we_q ? S_IDLE : S_WAIT_RD;
        end else if (timeout_hit) begin
          bus_req   = 1'b0;
          glock_req = 1'b0;
          state_d   = S_IDLE;
        end
      end

      S_WAIT_RD: begin
        glock_req = ~bus_rvalid;
        if (bus_rvalid) begin
          rdata_buf_d = bus_rdata;
          lsu_rdata   = bus_rdata;
          if (glock_other) begin
            state_d = S_HOLD;
          end else if (acc) begin
            state_d = acc_next;
          end else begin
            state_d = S_IDLE;
          end
        end else if (timeout_hit) begin
          lsu_rdata = 32'hDEAD_BEEF;
          glock_req = 1'b0;
          state_d   = S_IDLE;
        end
      end

      S_HOLD: begin
        // The data is parked in rdata_buf until the other lock source lets go
        if (!glock_other) begin
          state_d = acc ? acc_next : S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and data registers. The bus is reset together with the
  // bridge, so any outstanding response is dropped on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      req_we_q    <= 1'b0;
      req_be_q    <= 4'h0;
      req_addr_q  <= '0;
      req_wdata_q <= 32'h0;
      rdata_buf_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_be_q    <= req_be_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

endmodule

// File: tb/tb_tta_lsu_mem_bridge.sv
// Testbench for tta_lsu_mem_bridge.
// It drives FU and bus stimulus at the falling edge and checks outputs 1 ns
// later. Expected values come from transaction parameters: grant delay, extra
// rvalid delay, hold length and the FU request fields. The checks cover the
// MEM_BRIDGE_TIMEOUT_EN abort behaviour when that macro is defined.
module tb_tta_lsu_mem_bridge;

  localparam int ADDR_W = 22;

  logic              clk;
  logic              reset;
  logic              lsu_mem_en_x;
  logic              lsu_wr_en_x;
  logic [31:0]       lsu_wr_mask_x;
  logic [ADDR_W-1:0] lsu_addr;
  logic [31:0]       lsu_wdata;
  logic [31:0]       lsu_rdata;
  logic              glock_other;
  logic              glock_req;
  logic              bus_req;
  logic              bus_we;
  logic [3:0]        bus_be;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;
`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic              bus_err;
`endif

  int          n_tests;
  int          n_fail;
  logic [31:0] last_rd;

  tta_lsu_mem_bridge #(
`ifdef MEM_BRIDGE_TIMEOUT_EN
    .TIMEOUT_CYC (8),
`endif
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .lsu_mem_en_x  (lsu_mem_en_x),
    .lsu_wr_en_x   (lsu_wr_en_x),
    .lsu_wr_mask_x (lsu_wr_mask_x),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_rdata     (lsu_rdata),
    .glock_other   (glock_other),
    .glock_req     (glock_req),
`ifdef MEM_BRIDGE_TIMEOUT_EN
    .bus_err       (bus_err),
`endif
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_be        (bus_be),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_gnt       (bus_gnt),
    .bus_rvalid    (bus_rvalid),
    .bus_rdata     (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus: drive at the falling edge, then settle 1 ns
  task automatic set_in(input logic en_x, input logic wr_x, input logic [31:0] m,
                        input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                        input logic gnt, input logic rv, input logic [31:0] rd,
                        input logic go);
    @(negedge clk);
    lsu_mem_en_x  = en_x;
    lsu_wr_en_x   = wr_x;
    lsu_wr_mask_x = m;
    lsu_addr      = a;
    lsu_wdata     = wd;
    bus_gnt       = gnt;
    bus_rvalid    = rv;
    bus_rdata     = rd;
    glock_other   = go;
    #1;
  endtask

  // One FU transaction. The FU requests in cycle 0. The grant arrives in
  // cycle g. A read's data arrives r cycles later than the nominal cycle
  // g+1. On a read, glock_other is held for 'hold' cycles from the data
  // cycle onward.
  task automatic run_txn(input bit wr, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                         input logic [31:0] m, input int g, input int r,
                         input logic [31:0] rd, input int hold);
    logic [3:0] be_exp;
    int         end_c;
    int         last_c;
    int         stall_exp;
    int         stalls;
    logic       gnt;
    logic       rv;
    logic       go;
    logic [31:0] rdv;
    be_exp    = wr ? ~{m[24], m[16], m[8], m[0]} : 4'hF;
    end_c     = wr ? g : g + 1 + r;
    last_c    = wr ? g : end_c + hold;
    stall_exp = wr ? g : g + r;
    stalls    = 0;
    for (int c = 0; c <= last_c; c++) begin
      rdv = $urandom;
      if (c <= g) begin
        gnt = (c == g);
        rv  = 1'($urandom_range(1));     // rvalid is ignored outside a read wait
      end else if (c < end_c) begin
        gnt = 1'($urandom_range(1));     // grant without a request is ignored
        rv  = 1'b0;
      end else begin
        gnt = 1'b0;
        rv  = (c == end_c);
        if (c == end_c) rdv = rd;
      end
      go = !wr && (c >= end_c) && (c < end_c + hold);
      if (c == 0)
        set_in(1'b0, ~wr, m, a, wd, gnt, rv, rdv, 1'b0);
      else
        set_in(1'b1, 1'($urandom_range(1)), $urandom, ADDR_W'($urandom), $urandom,
               gnt, rv, rdv, go);

      chk("bus_req", bus_req, (c <= g));
      if (c <= g) begin
        chk("bus_we", bus_we, wr);
        chk("bus_be", bus_be, be_exp);
        chk("bus_addr", bus_addr, a);
        if (wr) chk("bus_wdata", bus_wdata, wd);
      end
      chk("glock_req", glock_req, (c >= 1) && (c <= stall_exp));
      if (glock_req === 1'b1) stalls++;
      if (!wr && c >= end_c) chk("lsu_rdata_new", lsu_rdata, rd);
      else                   chk("lsu_rdata_buf", lsu_rdata, last_rd);
    end
    chk("stall_count", stalls, stall_exp);
    if (!wr) last_rd = rd;
  endtask

  // Bus/FU idle cycles with stray grant/rvalid/lock activity
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(1'b1, 1'($urandom_range(1)), $urandom, ADDR_W'($urandom), $urandom,
             1'($urandom_range(1)), 1'($urandom_range(1)), $urandom,
             1'($urandom_range(1)));
      chk("idle_bus_req", bus_req, 1'b0);
      chk("idle_glock", glock_req, 1'b0);
      chk("idle_rdata", lsu_rdata, last_rd);
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] a1, a2;
    logic [31:0]       d1, d2, wd;
    bit                wr;
    n_tests = 0;
    n_fail  = 0;
    last_rd = 32'h0;
    reset   = 1'b0;

    // Reset state. An FU request during reset must not reach the bus.
    set_in(1'b0, 1'b1, 32'hFFFF_FFFF, 22'h3FF, 32'h1, 1'b1, 1'b1, 32'h5, 1'b0);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_glock", glock_req, 1'b0);
    chk("rst_rdata", lsu_rdata, 32'h0);
    chk("rst_bus_addr", bus_addr, 22'h0);
    chk("rst_bus_we", bus_we, 1'b0);
    chk("rst_bus_be", bus_be, 4'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    set_in(1'b1, 1'b1, '1, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    reset = 1'b1;
    idle_cycles(2);

    // Write with bytes 0..1 enabled, granted immediately
    run_txn(1'b1, 22'h00010, 32'hA5A5_5A5A, 32'hFFFF_FEFE, 0, 0, 32'h0, 0);
    // Zero-stall read
    run_txn(1'b0, 22'h00020, 32'h0, 32'hFFFF_FFFF, 0, 0, 32'h1234_5678, 0);
    // Late grant and late rvalid: 3 + 2 stall cycles
    run_txn(1'b0, 22'h12345, 32'h0, 32'hFFFF_FFFF, 3, 2, 32'h0BAD_F00D, 0);
    // Read data arrives while another unit holds the lock for 4 cycles
    run_txn(1'b0, 22'h00040, 32'h0, 32'hFFFF_FFFF, 0, 0, 32'hCAFE_F00D, 4);
    idle_cycles(2);

    // Back-to-back reads: the second request issues in the first's rvalid cycle
    a1 = ADDR_W'($urandom); a2 = ADDR_W'($urandom); d1 = $urandom; d2 = $urandom;
    set_in(1'b0, 1'b1, '1, a1, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("b2b_req1", bus_req, 1'b1);
    chk("b2b_addr1", bus_addr, a1);
    set_in(1'b0, 1'b1, '1, a2, '0, 1'b1, 1'b1, d1, 1'b0);
    chk("b2b_req2", bus_req, 1'b1);
    chk("b2b_addr2", bus_addr, a2);
    chk("b2b_we2", bus_we, 1'b0);
    chk("b2b_glock2", glock_req, 1'b0);
    chk("b2b_rdata1", lsu_rdata, d1);
    set_in(1'b1, 1'b1, '1, '0, '0, 1'b0, 1'b1, d2, 1'b0);
    chk("b2b_rdata2", lsu_rdata, d2);
    chk("b2b_glock3", glock_req, 1'b0);
    chk("b2b_req3", bus_req, 1'b0);
    last_rd = d2;

    // Back-to-back read then write, where the write waits one cycle for its grant
    d1 = $urandom; wd = $urandom;
    set_in(1'b0, 1'b1, '1, a1, '0, 1'b1, 1'b0, '0, 1'b0);
    set_in(1'b0, 1'b0, 32'hFEFF_FFFF, a2, wd, 1'b0, 1'b1, d1, 1'b0);
    chk("b2bw_req", bus_req, 1'b1);
    chk("b2bw_we", bus_we, 1'b1);
    chk("b2bw_be", bus_be, 4'b1000);
    chk("b2bw_rdata", lsu_rdata, d1);
    set_in(1'b1, 1'b1, $urandom, ADDR_W'($urandom), $urandom, 1'b1, 1'b0, $urandom, 1'b0);
    chk("b2bw_glock", glock_req, 1'b1);
    chk("b2bw_req_hold", bus_req, 1'b1);
    chk("b2bw_addr_hold", bus_addr, a2);
    chk("b2bw_wdata_hold", bus_wdata, wd);
    last_rd = d1;
    idle_cycles(1);

    // Randomised transactions
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(1));
      run_txn(wr, ADDR_W'($urandom), $urandom, $urandom, $urandom_range(3),
              $urandom_range(3), $urandom, wr ? 0 : $urandom_range(3));
      idle_cycles($urandom_range(2));
    end

`ifdef MEM_BRIDGE_TIMEOUT_EN
    // Read with no response: 8 stall cycles, then abort
    set_in(1'b0, 1'b1, '1, 22'h00100, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("to_err_init", bus_err, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      set_in(1'b1, 1'b1, '1, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      chk("to_rd_glock", glock_req, 1'b1);
    end
    set_in(1'b1, 1'b1, '1, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("to_rd_deadbeef", lsu_rdata, 32'hDEAD_BEEF);
    chk("to_rd_glock_off", glock_req, 1'b0);
    chk("to_rd_req_off", bus_req, 1'b0);
    set_in(1'b1, 1'b1, '1, '0, '0, 1'b0, 1'b1, 32'h7777_7777, 1'b0);
    chk("to_rd_err", bus_err, 1'b1);
    chk("to_rd_late_rv", lsu_rdata, last_rd);
    chk("to_rd_glock_idle", glock_req, 1'b0);
    // Write never granted
    set_in(1'b0, 1'b0, 32'h0, 22'h00200, 32'h1, 1'b0, 1'b0, '0, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      set_in(1'b1, 1'b1, '1, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      chk("to_gnt_req", bus_req, 1'b1);
      chk("to_gnt_glock", glock_req, 1'b1);
    end
    set_in(1'b1, 1'b1, '1, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("to_gnt_req_off", bus_req, 1'b0);
    chk("to_gnt_glock_off", glock_req, 1'b0);
    set_in(1'b1, 1'b1, '1, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("to_gnt_stray", bus_req, 1'b0);
`endif

    // Asynchronous reset in the middle of a read wait
    set_in(1'b0, 1'b1, '1, 22'h2AAAA, '0, 1'b1, 1'b0, '0, 1'b0);
    set_in(1'b1, 1'b1, '1, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("mid_rd_glock", glock_req, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_bus_req", bus_req, 1'b0);
    chk("arst_glock", glock_req, 1'b0);
    chk("arst_rdata", lsu_rdata, 32'h0);
    chk("arst_bus_addr", bus_addr, 22'h0);
    chk("arst_bus_be", bus_be, 4'h0);
`ifdef MEM_BRIDGE_TIMEOUT_EN
    chk("arst_bus_err", bus_err, 1'b0);
`endif
    set_in(1'b1, 1'b1, '1, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    reset   = 1'b1;
    last_rd = 32'h0;
    // A response from before the reset is dropped
    set_in(1'b1, 1'b1, '1, '0, '0, 1'b0, 1'b1, 32'h9999_9999, 1'b0);
    chk("arst_drop_rdata", lsu_rdata, 32'h0);
    chk("arst_drop_glock", glock_req, 1'b0);
    run_txn(1'b0, 22'h00033, 32'h0, 32'hFFFF_FFFF, 1, 1, 32'h3C3C_A5A5, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
